// File: rtl/fsx_output_stage.sv
// Final GPU pixel stage: aligns sync to the renderer latency, blanks, applies a frame-synchronous
// brightness fade and registers the LCD/VGA pins. Emits a one-cycle frame_start on vsync fall.
module fsx_output_stage #(
   parameter int PIPE_DEPTH  = 2,
   parameter int FADE_FRAMES = 4
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic [2:0] in_r,
   input  logic [2:0] in_g,
   input  logic [1:0] in_b,
   input  logic       in_hs,
   input  logic       in_vs,
   input  logic       in_de,
   input  logic       fade_out_req,
   input  logic       fade_in_req,
   output logic [2:0] vga_r,
   output logic [2:0] vga_g,
   output logic [1:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_de,
   output logic       frame_start,
   output logic [3:0] fade_level,
   output logic       fade_busy
);

   typedef enum logic [1:0] {S_VISIBLE, S_FADING_OUT, S_BLACK, S_FADING_IN} state_t;

   localparam logic [7:0] CNT_LAST = 8'(FADE_FRAMES - 1);

   // {hs, vs, de} after the alignment delay
   logic [2:0] w_sync_d;

   generate
      if (PIPE_DEPTH == 0) begin : g_bypass
         assign w_sync_d = {in_hs, in_vs, in_de};
      end else begin : g_pipe
         logic [2:0] r_sync_pipe [PIPE_DEPTH];
         always_ff @(posedge vga_clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < PIPE_DEPTH; i++) r_sync_pipe[i] <= 3'b110;
            end else begin
               r_sync_pipe[0] <= {in_hs, in_vs, in_de};
               for (int i = 1; i < PIPE_DEPTH; i++) r_sync_pipe[i] <= r_sync_pipe[i-1];
            end
         end
         assign w_sync_d = r_sync_pipe[PIPE_DEPTH-1];
      end
   endgenerate

   state_t     r_state, w_state_nx;
   logic [3:0] r_level, w_level_nx;
   logic [7:0] r_cnt,   w_cnt_nx;
   logic [2:0] r_r, r_g;
   logic [1:0] r_b;
   logic       r_hs, r_vs, r_de, r_fs;

   logic [6:0] w_r_prod, w_g_prod;
   logic [5:0] w_b_prod;
   logic [2:0] w_r_sc, w_g_sc;
   logic [1:0] w_b_sc;
   logic       w_busy, w_fade_in;

   assign w_r_prod = {4'b0, in_r} * {3'b0, r_level};
   assign w_g_prod = {4'b0, in_g} * {3'b0, r_level};
   assign w_b_prod = {4'b0, in_b} * {2'b0, r_level};
   assign w_r_sc   = 3'(w_r_prod >> 3);
   assign w_g_sc   = 3'(w_g_prod >> 3);
   assign w_b_sc   = 2'(w_b_prod >> 3);

   // Colour is blanked by the delayed de so pins stay coherent with vga_de.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_r  <= '0;
         r_g  <= '0;
         r_b  <= '0;
         r_hs <= 1'b1;
         r_vs <= 1'b1;
         r_de <= 1'b0;
         r_fs <= 1'b0;
      end else begin
         r_r  <= w_sync_d[0] ? w_r_sc : 3'd0;
         r_g  <= w_sync_d[0] ? w_g_sc : 3'd0;
         r_b  <= w_sync_d[0] ? w_b_sc : 2'd0;
         r_hs <= w_sync_d[2];
         r_vs <= w_sync_d[1];
         r_de <= w_sync_d[0];
         r_fs <= r_vs & ~w_sync_d[1];
      end
   end

   assign w_busy    = (r_state == S_FADING_OUT) || (r_state == S_FADING_IN);
   assign w_fade_in = fade_in_req & ~fade_out_req;

   always_comb begin
      w_state_nx = r_state;
      w_level_nx = r_level;
      w_cnt_nx   = r_cnt;
      if (fade_out_req && (r_state == S_VISIBLE || r_state == S_FADING_IN)) begin
         w_state_nx = S_FADING_OUT;
         w_cnt_nx   = '0;
      end else if (w_fade_in && (r_state == S_BLACK || r_state == S_FADING_OUT)) begin
         w_state_nx = S_FADING_IN;
         w_cnt_nx   = '0;
      end else if (r_fs && w_busy) begin
         if (r_cnt == CNT_LAST) begin
            w_cnt_nx = '0;
            if (r_state == S_FADING_OUT) begin
               w_level_nx = r_level - 4'd1;
               if (r_level == 4'd1) w_state_nx = S_BLACK;
            end else begin
               w_level_nx = r_level + 4'd1;
               if (r_level == 4'd7) w_state_nx = S_VISIBLE;
            end
         end else begin
            w_cnt_nx = r_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_state <= S_VISIBLE;
         r_level <= 4'd8;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_level <= w_level_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   assign vga_r       = r_r;
   assign vga_g       = r_g;
   assign vga_b       = r_b;
   assign vga_hs      = r_hs;
   assign vga_vs      = r_vs;
   assign vga_de      = r_de;
   assign frame_start = r_fs;
   assign fade_level  = r_level;
   assign fade_busy   = w_busy;

endmodule

// File: doc/fsx_output_stage.md
Name: fsx_output_stage

Overview:
- Final pixel stage of the GPU, directly downstream of the frame synthesizer's timing generator and background/window renderer.
- Takes RGB332 pixels plus hs/vs/de and re-aligns the sync signals to the renderer's pixel latency.
- Applies blanking and a frame-synchronous global brightness fade, then drives the registered LCD/VGA pins.
- Produces a one-cycle frame_start pulse for the interrupt logic.

Parameters:
- PIPE_DEPTH, 2: clock delay applied to in_hs/in_vs/in_de to match renderer colour latency; legal range 0..4.
- FADE_FRAMES, 4: number of frame_start pulses per fade step; legal range 1..255.

Ports:
- vga_clk  in  1  pixel clock (9 MHz).
- reset  in  1  asynchronous, active-high.
- in_r  in  3  renderer red.
- in_g  in  3  renderer green.
- in_b  in  2  renderer blue.
- in_hs  in  1  timing generator hsync, active-low.
- in_vs  in  1  timing generator vsync, active-low.
- in_de  in  1  timing generator display enable.
- fade_out_req  in  1  single-cycle request to fade to black.
- fade_in_req  in  1  single-cycle request to fade to full brightness.
- vga_r  out  3  registered red.
- vga_g  out  3  registered green.
- vga_b  out  2  registered blue.
- vga_hs  out  1  aligned hsync.
- vga_vs  out  1  aligned vsync.
- vga_de  out  1  aligned display enable.
- frame_start  out  1  one-cycle pulse at each falling edge of aligned vsync.
- fade_level  out  4  current brightness level, 0..8.
- fade_busy  out  1  high while a fade is in progress.

Behaviour:
- Clocking and reset: one clock, vga_clk. Reset is asynchronous and active-high.
- Reset values:
  - vga_r/g/b = 0, vga_de = 0, vga_hs = vga_vs = 1, frame_start = 0.
  - Sync shift registers: hs = 1, vs = 1, de = 0.
  - fade_level = 8, state VISIBLE, frame counter = 0, fade_busy = 0.
- Sync alignment: in_hs/in_vs/in_de pass through a PIPE_DEPTH-stage shift register, then the output register. Latency is PIPE_DEPTH+1 cycles. With PIPE_DEPTH = 0 the shift register is bypassed.
- Colour path: in_r/g/b go through the output register only, latency 1 cycle, and are aligned with delayed de.
- Scaling:
  - vga_r = (in_r * fade_level) >> 3, using a 7-bit intermediate. Green uses the same rule.
  - vga_b = (in_b * fade_level) >> 3, using a 6-bit intermediate.
  - Level 8 is exact identity; level 0 gives black.
- Blanking: if delayed de = 0, colour outputs are forced to 0 regardless of inputs or level.
- frame_start: asserted for one cycle, together with the output register, when delayed vs goes 1 to 0 (detected at the last delay stage). It is never asserted while in reset.
- FSM states: VISIBLE (level 8), FADING_OUT, BLACK (level 0), FADING_IN. fade_busy = 1 in FADING_OUT and FADING_IN.
- Transitions on requests:
  - fade_out_req in VISIBLE or FADING_IN: go to FADING_OUT, clear frame counter, keep current level.
  - fade_in_req in BLACK or FADING_OUT: go to FADING_IN, clear frame counter, keep current level.
  - Requests in any other state are ignored: fade_out in BLACK/FADING_OUT, fade_in in VISIBLE/FADING_IN.
  - If both requests arrive in the same cycle, fade_out_req wins.
  - If a request arrives in the same cycle as frame_start, the request is applied and no level step occurs in that cycle.
- Level stepping:
  - Only in a FADING state, and only on a cycle with frame_start = 1.
  - If counter == FADE_FRAMES-1: counter is cleared and the level steps by -1 (out) or +1 (in). Otherwise the counter increments.
  - When the level reaches 0, go to BLACK. When it reaches 8, go to VISIBLE.
- Tearing: a new level applies to pixels from the following cycle. frame_start falls inside vertical blanking, so no visible frame is ever drawn with two levels.
- Reset mid-fade: immediately returns to VISIBLE at level 8 and drops any in-flight pipeline contents.

Test Plan:
- Reset: assert reset with arbitrary inputs → vga_r/g/b = 0, hs = vs = 1, de = 0, fade_level = 8, fade_busy = 0, frame_start = 0. Release reset → no spurious frame_start.
- Passthrough (PIPE_DEPTH = 2): in_de = 1, in_r = 5, in_g = 3, in_b = 2 → 5/3/2 after 1 cycle. Drop de → colour 0 three cycles later. in_hs pulse → vga_hs pulse 3 cycles later, same width.
- Fade out (FADE_FRAMES = 1, in_r = 7, in_b = 3): pulse fade_out_req, then 8 vs falling edges → fade_level 7..0, vga_r 6, 5, 4, 3, 2, 1, 0, 0, vga_b 2, 2, 1, 1, 1, 0, 0, 0. State BLACK, fade_busy = 0 after the 8th edge.
- FADE_FRAMES = 4: fade_out_req, then 12 frames → level changes only on frames 4, 8, 12, ending at level 5.
- Reversal and priority:
  - fade_in_req while FADING_OUT at level 5 → level 6, 7, 8 on following steps, ends VISIBLE.
  - Simultaneous fade_out_req and fade_in_req in VISIBLE → FADING_OUT.
  - fade_in_req alone in VISIBLE → ignored.
- Async reset at level 3 while FADING_OUT, asserted mid-clock → outputs clear without waiting for a clock edge, level 8, VISIBLE.
